// File: rtl/a2mem_switch_tracker_if.sv
// ============================================================================
// a2mem_switch_tracker_if : Apple II soft-switch / video state bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface a2mem_switch_tracker_if;
  logic       TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE;
  logic       AN0, AN1, AN2, AN3;
  logic       STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR;
  logic [2:0] SLOTROM;
  logic       INTC8ROM;
  logic [7:0] VIDEX_CRTC_R9, VIDEX_CRTC_R10, VIDEX_CRTC_R11, VIDEX_CRTC_R12;
  logic [7:0] VIDEX_CRTC_R13, VIDEX_CRTC_R14, VIDEX_CRTC_R15;
  logic       VIDEX_MODE;
  logic [3:0] TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR;
  logic       SHRG_MODE, LINEARIZE_MODE, MONOCHROME_DHIRES_MODE, MONOCHROME_MODE;
  logic       aux_mem;
  logic [7:0] keycode;
  logic       keypress_strobe;

  modport master (
    output TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3,
           STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR,
           SLOTROM, INTC8ROM,
           VIDEX_CRTC_R9, VIDEX_CRTC_R10, VIDEX_CRTC_R11, VIDEX_CRTC_R12,
           VIDEX_CRTC_R13, VIDEX_CRTC_R14, VIDEX_CRTC_R15, VIDEX_MODE,
           TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR,
           SHRG_MODE, LINEARIZE_MODE, MONOCHROME_DHIRES_MODE, MONOCHROME_MODE,
           aux_mem, keycode, keypress_strobe
  );

  modport monitor (
    input  TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3,
           STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR,
           SLOTROM, INTC8ROM,
           VIDEX_CRTC_R9, VIDEX_CRTC_R10, VIDEX_CRTC_R11, VIDEX_CRTC_R12,
           VIDEX_CRTC_R13, VIDEX_CRTC_R14, VIDEX_CRTC_R15, VIDEX_MODE,
           TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR,
           SHRG_MODE, LINEARIZE_MODE, MONOCHROME_DHIRES_MODE, MONOCHROME_MODE,
           aux_mem, keycode, keypress_strobe
  );
endinterface

`default_nettype wire

// File: rtl/a2mem_switch_tracker.sv
// ============================================================================
// a2mem_switch_tracker : snoops Apple II bus cycles and tracks soft switches
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module a2mem_switch_tracker #(
  parameter int ENABLE_VIDEX = 1,
  parameter int ENABLE_IIGS  = 1
) (
  input  logic                          clk_logic,
  input  logic                          system_reset_n,
  input  logic [15:0]                   addr,
  input  logic [7:0]                    data,
  input  logic                          rw_n,
  input  logic                          data_strobe,
  a2mem_switch_tracker_if.master        a2mem_if
);

  localparam logic [0:0] KBD_IDLE = 1'b0;
  localparam logic [0:0] KBD_HELD = 1'b1;

  // vid_sw bit order: TEXT, MIXED, PAGE2, HIRES, AN0..AN3
  // mem_sw bit order: STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR
  logic [7:0]      vid_sw_q, vid_sw_d;
  logic [7:0]      mem_sw_q, mem_sw_d;
  logic [2:0]      slotrom_q, slotrom_d;
  logic            intc8rom_q, intc8rom_d;
  logic [4:0]      crtc_idx_q, crtc_idx_d;
  logic [6:0][7:0] crtc_q, crtc_d;
  logic [3:0]      text_color_q, text_color_d;
  logic [3:0]      bg_color_q, bg_color_d;
  logic [3:0]      border_color_q, border_color_d;
  logic            shrg_q, shrg_d;
  logic            linearize_q, linearize_d;
  logic            mono_dhires_q, mono_dhires_d;
  logic            mono_q, mono_d;
  logic            aux_mem_q, aux_mem_d;
  logic [7:0]      keycode_q, keycode_d;
  logic            keypress_strobe_q, keypress_strobe_d;
  logic [0:0]      kbd_state_q, kbd_state_d;

  logic       w_is_c00x, w_is_c01x, w_is_c05x, w_is_slot, w_is_cfff;
  logic       w_wr;
  logic [4:0] w_crtc_sel;

  assign w_wr       = ~rw_n;
  assign w_is_c00x  = (addr[15:4] == 12'hC00);
  assign w_is_c01x  = (addr[15:4] == 12'hC01);
  assign w_is_c05x  = (addr[15:4] == 12'hC05);
  assign w_is_slot  = (addr[15:12] == 4'hC) && (addr[11:8] != 4'h0) && (addr[11:8] <= 4'h7);
  assign w_is_cfff  = (addr == 16'hCFFF);
  assign w_crtc_sel = crtc_idx_q - 5'd9;

  always_comb begin
    vid_sw_d          = vid_sw_q;
    mem_sw_d          = mem_sw_q;
    slotrom_d         = slotrom_q;
    intc8rom_d        = intc8rom_q;
    crtc_idx_d        = crtc_idx_q;
    crtc_d            = crtc_q;
    text_color_d      = text_color_q;
    bg_color_d        = bg_color_q;
    border_color_d    = border_color_q;
    shrg_d            = shrg_q;
    linearize_d       = linearize_q;
    mono_dhires_d     = mono_dhires_q;
    mono_d            = mono_q;
    aux_mem_d         = aux_mem_q;
    keycode_d         = keycode_q;
    keypress_strobe_d = 1'b0;
    kbd_state_d       = kbd_state_q;

    if (data_strobe) begin
      // Bank selection always uses the switch values from before this access
      if ((addr < 16'h0200) || (addr >= 16'hD000))
        aux_mem_d = mem_sw_q[4];
      else if ((addr >= 16'h0400) && (addr <= 16'h07FF) && mem_sw_q[0])
        aux_mem_d = vid_sw_q[2];
      else if ((addr >= 16'h2000) && (addr <= 16'h3FFF) && mem_sw_q[0] && vid_sw_q[3])
        aux_mem_d = vid_sw_q[2];
      else if (addr < 16'hC000)
        aux_mem_d = rw_n ? mem_sw_q[1] : mem_sw_q[2];
      else
        aux_mem_d = 1'b0;

      if (w_is_c05x)
        vid_sw_d[addr[3:1]] = addr[0];
      if (w_is_c00x && w_wr)
        mem_sw_d[addr[3:1]] = addr[0];

      if (w_is_slot) begin
        slotrom_d = addr[10:8];
        if ((addr[11:8] == 4'h3) && !mem_sw_q[5])
          intc8rom_d = 1'b1;
      end
      if (w_is_cfff) begin
        slotrom_d  = 3'd0;
        intc8rom_d = 1'b0;
      end

      if (ENABLE_VIDEX != 0) begin
        if (w_wr && (addr == 16'hC0B0))
          crtc_idx_d = data[4:0];
        if (w_wr && (addr == 16'hC0B1) && (crtc_idx_q >= 5'd9) && (crtc_idx_q <= 5'd15))
          crtc_d[w_crtc_sel[2:0]] = data;
      end

      if ((ENABLE_IIGS != 0) && w_wr) begin
        case (addr)
          16'hC022: begin
            text_color_d = data[7:4];
            bg_color_d   = data[3:0];
          end
          16'hC034: border_color_d = data[3:0];
          16'hC029: begin
            shrg_d        = data[7];
            linearize_d   = data[6];
            mono_dhires_d = data[5];
          end
          16'hC021: mono_d = data[7];
          default: ;
        endcase
      end

      case (kbd_state_q)
        KBD_IDLE: begin
          if (w_is_c00x && rw_n && data[7]) begin
            keycode_d         = data;
            keypress_strobe_d = 1'b1;
            kbd_state_d       = KBD_HELD;
          end
        end
        default: begin
          if (w_is_c01x)
            kbd_state_d = KBD_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      vid_sw_q          <= 8'h01;
      mem_sw_q          <= 8'h00;
      slotrom_q         <= 3'd0;
      intc8rom_q        <= 1'b0;
      crtc_idx_q        <= 5'd0;
      crtc_q            <= '0;
      text_color_q      <= 4'hF;
      bg_color_q        <= 4'h0;
      border_color_q    <= 4'h0;
      shrg_q            <= 1'b0;
      linearize_q       <= 1'b0;
      mono_dhires_q     <= 1'b0;
      mono_q            <= 1'b0;
      aux_mem_q         <= 1'b0;
      keycode_q         <= 8'h00;
      keypress_strobe_q <= 1'b0;
      kbd_state_q       <= KBD_IDLE;
    end else begin
      vid_sw_q          <= vid_sw_d;
      mem_sw_q          <= mem_sw_d;
      slotrom_q         <= slotrom_d;
      intc8rom_q        <= intc8rom_d;
      crtc_idx_q        <= crtc_idx_d;
      crtc_q            <= crtc_d;
      text_color_q      <= text_color_d;
      bg_color_q        <= bg_color_d;
      border_color_q    <= border_color_d;
      shrg_q            <= shrg_d;
      linearize_q       <= linearize_d;
      mono_dhires_q     <= mono_dhires_d;
      mono_q            <= mono_d;
      aux_mem_q         <= aux_mem_d;
      keycode_q         <= keycode_d;
      keypress_strobe_q <= keypress_strobe_d;
      kbd_state_q       <= kbd_state_d;
    end
  end

  assign a2mem_if.TEXT_MODE              = vid_sw_q[0];
  assign a2mem_if.MIXED_MODE             = vid_sw_q[1];
  assign a2mem_if.PAGE2                  = vid_sw_q[2];
  assign a2mem_if.HIRES_MODE             = vid_sw_q[3];
  assign a2mem_if.AN0                    = vid_sw_q[4];
  assign a2mem_if.AN1                    = vid_sw_q[5];
  assign a2mem_if.AN2                    = vid_sw_q[6];
  assign a2mem_if.AN3                    = vid_sw_q[7];
  assign a2mem_if.STORE80                = mem_sw_q[0];
  assign a2mem_if.RAMRD                  = mem_sw_q[1];
  assign a2mem_if.RAMWRT                 = mem_sw_q[2];
  assign a2mem_if.INTCXROM               = mem_sw_q[3];
  assign a2mem_if.ALTZP                  = mem_sw_q[4];
  assign a2mem_if.SLOTC3ROM              = mem_sw_q[5];
  assign a2mem_if.COL80                  = mem_sw_q[6];
  assign a2mem_if.ALTCHAR                = mem_sw_q[7];
  assign a2mem_if.SLOTROM                = slotrom_q;
  assign a2mem_if.INTC8ROM               = intc8rom_q;
  assign a2mem_if.VIDEX_CRTC_R9          = crtc_q[0];
  assign a2mem_if.VIDEX_CRTC_R10         = crtc_q[1];
  assign a2mem_if.VIDEX_CRTC_R11         = crtc_q[2];
  assign a2mem_if.VIDEX_CRTC_R12         = crtc_q[3];
  assign a2mem_if.VIDEX_CRTC_R13         = crtc_q[4];
  assign a2mem_if.VIDEX_CRTC_R14         = crtc_q[5];
  assign a2mem_if.VIDEX_CRTC_R15         = crtc_q[6];
  assign a2mem_if.TEXT_COLOR             = text_color_q;
  assign a2mem_if.BACKGROUND_COLOR       = bg_color_q;
  assign a2mem_if.BORDER_COLOR           = border_color_q;
  assign a2mem_if.SHRG_MODE              = shrg_q;
  assign a2mem_if.LINEARIZE_MODE         = linearize_q;
  assign a2mem_if.MONOCHROME_DHIRES_MODE = mono_dhires_q;
  assign a2mem_if.MONOCHROME_MODE        = mono_q;
  assign a2mem_if.aux_mem                = aux_mem_q;
  assign a2mem_if.keycode                = keycode_q;
  assign a2mem_if.keypress_strobe        = keypress_strobe_q;

  generate
    if (ENABLE_VIDEX != 0) begin : g_videx_mode
      assign a2mem_if.VIDEX_MODE = vid_sw_q[4];
    end else begin : g_no_videx_mode
      assign a2mem_if.VIDEX_MODE = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_a2mem_switch_tracker.sv
// ============================================================================
// tb_a2mem_switch_tracker : scoreboard bench with a spec-level reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_a2mem_switch_tracker;

  logic        clk_logic = 1'b0;
  logic        system_reset_n = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  data = 8'h0;
  logic        rw_n = 1'b1;
  logic        data_strobe = 1'b0;

  always #5 clk_logic = ~clk_logic;

  a2mem_switch_tracker_if bus_if ();

  a2mem_switch_tracker #(.ENABLE_VIDEX(1), .ENABLE_IIGS(1)) dut (
    .clk_logic      (clk_logic),
    .system_reset_n (system_reset_n),
    .addr           (addr),
    .data           (data),
    .rw_n           (rw_n),
    .data_strobe    (data_strobe),
    .a2mem_if       (bus_if)
  );

  typedef logic [102:0] snap_t;
  typedef struct { snap_t s; logic [15:0] a; } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state, named after the architectural switches
  logic       m_text, m_mixed, m_page2, m_hires, m_an0, m_an1, m_an2, m_an3;
  logic       m_store80, m_ramrd, m_ramwrt, m_intcx, m_altzp, m_slotc3, m_col80, m_altchar;
  logic [2:0] m_slot;
  logic       m_c8;
  int         m_idx;
  logic [7:0] m_crtc [9:15];
  logic [3:0] m_tc, m_bg, m_bd;
  logic       m_shrg, m_lin, m_mdh, m_mono, m_aux, m_ks, m_held;
  logic [7:0] m_key;

  function automatic snap_t model_snap();
    return {m_an3, m_an2, m_an1, m_an0, m_hires, m_page2, m_mixed, m_text,
            m_altchar, m_col80, m_slotc3, m_altzp, m_intcx, m_ramwrt, m_ramrd, m_store80,
            m_slot, m_c8,
            m_crtc[15], m_crtc[14], m_crtc[13], m_crtc[12], m_crtc[11], m_crtc[10], m_crtc[9],
            m_an0, m_tc, m_bg, m_bd, m_shrg, m_lin, m_mdh, m_mono, m_aux, m_key, m_ks};
  endfunction

  function automatic snap_t dut_snap();
    return {bus_if.AN3, bus_if.AN2, bus_if.AN1, bus_if.AN0,
            bus_if.HIRES_MODE, bus_if.PAGE2, bus_if.MIXED_MODE, bus_if.TEXT_MODE,
            bus_if.ALTCHAR, bus_if.COL80, bus_if.SLOTC3ROM, bus_if.ALTZP,
            bus_if.INTCXROM, bus_if.RAMWRT, bus_if.RAMRD, bus_if.STORE80,
            bus_if.SLOTROM, bus_if.INTC8ROM,
            bus_if.VIDEX_CRTC_R15, bus_if.VIDEX_CRTC_R14, bus_if.VIDEX_CRTC_R13,
            bus_if.VIDEX_CRTC_R12, bus_if.VIDEX_CRTC_R11, bus_if.VIDEX_CRTC_R10,
            bus_if.VIDEX_CRTC_R9, bus_if.VIDEX_MODE,
            bus_if.TEXT_COLOR, bus_if.BACKGROUND_COLOR, bus_if.BORDER_COLOR,
            bus_if.SHRG_MODE, bus_if.LINEARIZE_MODE, bus_if.MONOCHROME_DHIRES_MODE,
            bus_if.MONOCHROME_MODE, bus_if.aux_mem, bus_if.keycode, bus_if.keypress_strobe};
  endfunction

  task automatic model_reset();
    {m_mixed, m_page2, m_hires, m_an0, m_an1, m_an2, m_an3} = '0;
    m_text = 1'b1;
    {m_store80, m_ramrd, m_ramwrt, m_intcx, m_altzp, m_slotc3, m_col80, m_altchar} = '0;
    m_slot = 3'd0; m_c8 = 1'b0; m_idx = 0;
    for (int i = 9; i <= 15; i++) m_crtc[i] = 8'h00;
    m_tc = 4'hF; m_bg = 4'h0; m_bd = 4'h0;
    {m_shrg, m_lin, m_mdh, m_mono, m_aux, m_ks, m_held} = '0;
    m_key = 8'h00;
  endtask

  task automatic model_access(input logic [15:0] a, input logic [7:0] d, input logic rd);
    int pair;
    logic v;
    // Bank choice is made from the switches as they stood before this access
    if (a < 16'h0200 || a >= 16'hD000)                                m_aux = m_altzp;
    else if (a >= 16'h0400 && a <= 16'h07FF && m_store80)             m_aux = m_page2;
    else if (a >= 16'h2000 && a <= 16'h3FFF && m_store80 && m_hires)  m_aux = m_page2;
    else if (a < 16'hC000)                                            m_aux = rd ? m_ramrd : m_ramwrt;
    else                                                              m_aux = 1'b0;
    m_ks = 1'b0;
    v = a[0];
    if (a >= 16'hC050 && a <= 16'hC05F) begin
      pair = (int'(a) - 'hC050) / 2;
      case (pair)
        0: m_text = v;  1: m_mixed = v; 2: m_page2 = v; 3: m_hires = v;
        4: m_an0 = v;   5: m_an1 = v;   6: m_an2 = v;   default: m_an3 = v;
      endcase
    end
    if (!rd && a >= 16'hC000 && a <= 16'hC00F) begin
      pair = (int'(a) - 'hC000) / 2;
      case (pair)
        0: m_store80 = v; 1: m_ramrd = v;  2: m_ramwrt = v; 3: m_intcx = v;
        4: m_altzp = v;   5: m_slotc3 = v; 6: m_col80 = v;  default: m_altchar = v;
      endcase
    end
    if (a >= 16'hC100 && a <= 16'hC7FF) begin
      m_slot = 3'((int'(a) - 'hC000) / 256);
      if (m_slot == 3'd3 && !m_slotc3) m_c8 = 1'b1;
    end
    if (a == 16'hCFFF) begin m_slot = 3'd0; m_c8 = 1'b0; end
    if (!rd && a == 16'hC0B0) m_idx = int'(d) % 32;
    if (!rd && a == 16'hC0B1 && m_idx >= 9 && m_idx <= 15) m_crtc[m_idx] = d;
    if (!rd && a == 16'hC022) begin m_tc = d[7:4]; m_bg = d[3:0]; end
    if (!rd && a == 16'hC034) m_bd = d[3:0];
    if (!rd && a == 16'hC029) begin m_shrg = d[7]; m_lin = d[6]; m_mdh = d[5]; end
    if (!rd && a == 16'hC021) m_mono = d[7];
    if (rd && a >= 16'hC000 && a <= 16'hC00F && !m_held && d[7]) begin
      m_key = d; m_ks = 1'b1; m_held = 1'b1;
    end
    if (a >= 16'hC010 && a <= 16'hC01F) m_held = 1'b0;
  endtask

  // Scoreboard monitor: one expected entry per reset or strobe edge, plus hold checks
  logic  event_seen = 1'b0;
  logic  armed = 1'b0, armed_q = 1'b0;
  snap_t last_exp = '0;

  always @(posedge clk_logic) begin
    event_seen <= data_strobe || !system_reset_n;
    armed_q    <= armed;
  end

  always @(negedge clk_logic) begin
    if (armed_q) begin
      snap_t act;
      exp_t  e;
      act = dut_snap();
      if (event_seen) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow act=%h exp=<none>", act);
        end else begin
          e = exp_q.pop_front();
          last_exp = e.s;
          if (act !== e.s) begin
            n_fail++;
            $display("FAIL access_%h act=%h exp=%h diff=%h", e.a, act, e.s, act ^ e.s);
          end
        end
      end else begin
        n_tests++;
        if (act !== {last_exp[102:1], 1'b0}) begin
          n_fail++;
          $display("FAIL hold act=%h exp=%h", act, {last_exp[102:1], 1'b0});
        end
      end
    end
  end

  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rd);
    exp_t e;
    @(negedge clk_logic);
    addr = a; data = d; rw_n = rd; data_strobe = 1'b1;
    model_access(a, d, rd);
    e.s = model_snap(); e.a = a;
    exp_q.push_back(e);
    @(posedge clk_logic);
    #1;
    data_strobe = 1'b0;
    addr = 16'($urandom); data = 8'($urandom); rw_n = 1'($urandom);
    repeat ($urandom_range(0, 2)) @(posedge clk_logic);
  endtask

  task automatic do_reset(input logic with_strobe);
    exp_t e;
    @(negedge clk_logic);
    armed = 1'b1;
    system_reset_n = 1'b0;
    data_strobe = with_strobe;
    addr = 16'hC057; data = 8'hC5; rw_n = 1'b0;
    model_reset();
    e.s = model_snap(); e.a = 16'h0000;
    exp_q.push_back(e);
    @(posedge clk_logic);
    #1;
    system_reset_n = 1'b1;
    data_strobe = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 11))
      0:  return 16'hC050 + 16'($urandom_range(0, 15));
      1:  return 16'hC000 + 16'($urandom_range(0, 15));
      2:  return 16'hC010 + 16'($urandom_range(0, 15));
      3:  return 16'hC000 + 16'($urandom_range(1, 7) * 256) + 16'($urandom_range(0, 255));
      4:  return 16'hCFFF;
      5:  return 16'hC0B0 + 16'($urandom_range(0, 1));
      6:  case ($urandom_range(0, 3))
            0: return 16'hC021; 1: return 16'hC022; 2: return 16'hC029; default: return 16'hC034;
          endcase
      7:  return 16'($urandom_range(0, 'h01FF));
      8:  return 16'($urandom_range('h0400, 'h07FF));
      9:  return 16'($urandom_range('h2000, 'h3FFF));
      10: return 16'($urandom_range('h0200, 'hBFFF));
      default: return 16'($urandom_range('hD000, 'hFFFF));
    endcase
  endfunction

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    repeat (3) @(posedge clk_logic);
    do_reset(1'b0);

    bus(16'hC051, 8'h00, 1'b1);
    bus(16'hC050, 8'h00, 1'b1);
    bus(16'hC057, 8'h00, 1'b0);

    bus(16'hC005, 8'h00, 1'b1);
    bus(16'hC005, 8'h00, 1'b0);
    bus(16'h4000, 8'h11, 1'b0);
    bus(16'h4000, 8'h22, 1'b1);

    bus(16'hC001, 8'h00, 1'b0);
    bus(16'hC055, 8'h00, 1'b0);
    bus(16'h0400, 8'h00, 1'b1);
    bus(16'hC000, 8'h00, 1'b0);
    bus(16'h0400, 8'h00, 1'b1);

    bus(16'hC3A0, 8'h00, 1'b1);
    bus(16'hCFFF, 8'h00, 1'b1);
    bus(16'hC00B, 8'h00, 1'b0);
    bus(16'hC300, 8'h00, 1'b1);
    bus(16'hC600, 8'h00, 1'b1);
    bus(16'hCFFF, 8'h00, 1'b0);

    bus(16'hC0B0, 8'h0E, 1'b0);
    bus(16'hC0B1, 8'h12, 1'b0);
    bus(16'hC0B0, 8'h03, 1'b0);
    bus(16'hC0B1, 8'h55, 1'b0);
    bus(16'hC0B0, 8'h09, 1'b0);
    bus(16'hC0B1, 8'hA7, 1'b0);
    bus(16'hC0B0, 8'h10, 1'b0);
    bus(16'hC0B1, 8'h66, 1'b0);

    bus(16'hC022, 8'h3C, 1'b0);
    bus(16'hC034, 8'hF7, 1'b0);
    bus(16'hC029, 8'hA0, 1'b0);
    bus(16'hC021, 8'h80, 1'b0);
    bus(16'hC022, 8'h99, 1'b1);

    bus(16'hC000, 8'hC1, 1'b1);
    bus(16'hC000, 8'hC2, 1'b1);
    bus(16'hC010, 8'h00, 1'b1);
    bus(16'hC000, 8'hC2, 1'b1);
    bus(16'hC0B0, 8'h0F, 1'b0);
    do_reset(1'b0);
    bus(16'hC000, 8'hC4, 1'b1);
    do_reset(1'b1);

    for (int i = 0; i < 600; i++) begin
      a = rand_addr();
      d = 8'($urandom);
      if (a == 16'hC0B0) d = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 79) == 0) do_reset(1'($urandom));
      else bus(a, d, 1'($urandom));
    end

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk_logic);
    repeat (2) @(posedge clk_logic);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain act=%0d exp=0 entries left", exp_q.size());
    end
    @(negedge clk_logic);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/a2mem_switch_tracker.md
A2MEM_SWITCH_TRACKER -- requirements
Module: a2mem_switch_tracker

Interface
REQ-001 SHALL have parameter ENABLE_VIDEX, default 1, enabling Videx CRTC capture and VIDEX_MODE.
REQ-002 SHALL have parameter ENABLE_IIGS, default 1, enabling IIgs color/mode register capture.
REQ-003 SHALL have port clk_logic  in  1  single clock; every state element is registered on its rising edge.
REQ-004 SHALL have port system_reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port addr  in  16  Apple II bus address of the current cycle.
REQ-006 SHALL have port data  in  8  Apple II bus data of the current cycle.
REQ-007 SHALL have port rw_n  in  1  bus direction (1 = read, 0 = write).
REQ-008 SHALL have port data_strobe  in  1  one-clk pulse marking addr/data/rw_n valid; exactly one per bus cycle.
REQ-009 SHALL have port a2mem_if  modport master  drives every interface signal as a registered output.

Function
REQ-010 SHALL act only on clocks where data_strobe=1; otherwise every output holds its value, except keypress_strobe, which returns to 0.
REQ-011 SHALL update outputs exactly 1 clk after the strobe edge; addr/data are sampled once and need not persist.
REQ-012 SHALL decode $C050-$C05F on read or write: even address clears and odd address sets the switch; pairs are TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3 ($C050/51 through $C05E/5F).
REQ-013 SHALL decode $C000-$C00F on writes only, with even clearing and odd setting: STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR, in order; reads leave these unchanged.
REQ-014 SHALL capture slot ROM on any access to $Cn00-$CnFF (n=1..7), setting SLOTROM=n.
REQ-015 SHALL set INTC8ROM=1 when n=3 and SLOTC3ROM=0.
REQ-016 SHALL clear both SLOTROM and INTC8ROM on any access to $CFFF; $CFFF takes priority over an earlier capture.
REQ-017 SHALL, when ENABLE_VIDEX=1, treat a write to $C0B0 as the CRTC index (data[4:0]) held in an internal 5-bit register.
REQ-018 SHALL, when ENABLE_VIDEX=1, treat a write to $C0B1 as a write of data to the CRTC register selected by the index, but only for index values 9-15, which map to VIDEX_CRTC_R9..R15; all other index values are ignored.
REQ-019 SHALL drive VIDEX_MODE = AN0 when ENABLE_VIDEX=1, and constant 0 otherwise.
REQ-020 SHALL, when ENABLE_VIDEX=0, hold all CRTC registers at their reset values.
REQ-021 SHALL, when ENABLE_IIGS=1, update on a write to $C022: TEXT_COLOR=data[7:4], BACKGROUND_COLOR=data[3:0].
REQ-022 SHALL, when ENABLE_IIGS=1, update on a write to $C034: BORDER_COLOR=data[3:0].
REQ-023 SHALL, when ENABLE_IIGS=1, update on a write to $C029: SHRG_MODE=data[7], LINEARIZE_MODE=data[6], MONOCHROME_DHIRES_MODE=data[5].
REQ-024 SHALL, when ENABLE_IIGS=1, update on a write to $C021: MONOCHROME_MODE=data[7].
REQ-025 SHALL hold all IIgs outputs at their reset values when ENABLE_IIGS=0.
REQ-026 SHALL run a two-state keyboard machine with states IDLE and HELD.
REQ-027 SHALL, in IDLE, on a read of $C000-$C00F with data[7]=1: set keycode=data, pulse keypress_strobe for 1 clk, and go to HELD.
REQ-028 SHALL, in HELD, ignore further $C000 reads, leaving keycode held and producing no strobe.
REQ-029 SHALL return to IDLE on any read or write of $C010-$C01F; keycode is retained.
REQ-030 SHALL compute aux_mem per strobe from the current address and switch state, evaluated in this order:
- addr < $0200 or addr >= $D000: ALTZP;
- $0400-$07FF with STORE80=1: PAGE2;
- $2000-$3FFF with STORE80=1 and HIRES_MODE=1: PAGE2;
- any other addr < $C000: RAMRD on reads, RAMWRT on writes;
- $C000-$CFFF: 0.
REQ-031 SHALL use switch values as they were before the current strobe when computing aux_mem; an access that changes a switch does not affect its own aux_mem.
REQ-032 SHALL ignore every other address, leaving state unchanged.

Reset
REQ-033 SHALL, while system_reset_n=0 at a clock edge, load all state; reset overrides a coincident data_strobe.
REQ-034 SHALL load TEXT_MODE=1 and every other switch 0 on reset.
REQ-035 SHALL load SLOTROM=0, INTC8ROM=0, the CRTC index and R9-R15 all 0, and VIDEX_MODE=0 on reset.
REQ-036 SHALL load TEXT_COLOR=4'hF, BACKGROUND_COLOR=0, BORDER_COLOR=0, all IIgs mode bits 0, aux_mem=0, keycode=0, keypress_strobe=0, and keyboard state IDLE on reset.
REQ-037 SHALL complete reset within the same clock even when asserted mid-operation (keyboard HELD, index loaded).

Verification
REQ-038 SHALL cover: reset, then read $C051 -> TEXT_MODE=1; read $C050 -> TEXT_MODE=0; write $C057 -> HIRES_MODE=1; all 1 clk after strobe.
REQ-039 SHALL cover: read $C005 -> RAMWRT stays 0; write $C005 -> RAMWRT=1; then write $4000 -> aux_mem=1 and read $4000 -> aux_mem=0.
REQ-040 SHALL cover: write $C001, write $C055, read $0400 -> aux_mem=1; then write $C000 and read $0400 -> aux_mem=0.
REQ-041 SHALL cover: SLOTC3ROM=0, read $C3A0 -> SLOTROM=3, INTC8ROM=1; read $CFFF -> both 0; with SLOTC3ROM=1, read $C300 -> INTC8ROM=0.
REQ-042 SHALL cover: write $C0B0=$0E, write $C0B1=$12 -> VIDEX_CRTC_R14=$12; write $C0B0=$03, write $C0B1=$55 -> R9-R15 unchanged.
REQ-043 SHALL cover: read $C000 data=$C1 -> keycode=$C1 and 1-clk keypress_strobe; read $C000 data=$C2 -> no strobe and keycode=$C1; read $C010, read $C000=$C2 -> keycode=$C2 with a strobe; reset asserted while HELD -> keycode=0 and state IDLE.
